oram_host_adapter: RTL and testbench

- Host-facing request engine placed directly upstream of the TinyORAM core.
- Accepts block-granular host read/write requests carrying a tag, range-checks each address, and issues one backend command per request on the core's Cmd/PAddr port.
- Streams write beats into the core's DataIn port. Buffers a full read block from the core's DataOut port so the core is never back-pressured by a slow host.
- Returns one tagged response per request; one request is outstanding at a time.

---
 rtl/oram_host_adapter.sv | 177 +++++++++++++++++
 tb/tb_oram_host_adapter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oram_host_adapter.sv
// Host request engine in front of the TinyORAM core: one tagged request
// in flight, write beats streamed through, read blocks buffered locally.
module oram_host_adapter #(
    parameter int ORAMB         = 512,
    parameter int ORAMU         = 32,
    parameter int FEDWidth      = 64,
    parameter int NumValidBlock = 1024,
    parameter int TagWidth      = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [ORAMU-1:0]    ReqAddr,
    input  logic [TagWidth-1:0] ReqTag,
    input  logic [FEDWidth-1:0] WData,
    input  logic                WDataValid,
    output logic                WDataReady,
    output logic [FEDWidth-1:0] RespData,
    output logic [TagWidth-1:0] RespTag,
    output logic                RespError,
    output logic                RespLast,
    output logic                RespValid,
    input  logic                RespReady,
    output logic [1:0]          Cmd,
    output logic [ORAMU-1:0]    PAddr,
    output logic                CmdValid,
    input  logic                CmdReady,
    output logic [FEDWidth-1:0] DataIn,
    output logic                DataInValid,
    input  logic                DataInReady,
    input  logic [FEDWidth-1:0] DataOut,
    input  logic                DataOutValid,
    output logic                DataOutReady
);

    localparam int Beats = ORAMB / FEDWidth;
    localparam int BeatW = $clog2(Beats);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [ORAMU-1:0] Limit = ORAMU'(NumValidBlock);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RDATA = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;

    localparam logic [1:0] CMD_UPDATE = 2'd0;
    localparam logic [1:0] CMD_READ   = 2'd2;

    logic [2:0]          state;
    logic [BeatW-1:0]    cnt;
    logic                is_write;
    logic                err;
    logic                armed;
    logic                buf_valid;
    logic [FEDWidth-1:0] buffer [Beats];

    logic accept;
    logic in_range;
    logic last_beat;
    logic din_fire;
    logic drain_fire;
    logic dout_fire;

    assign accept     = ReqValid && ReqReady;
    assign in_range   = ReqAddr < Limit;
    assign last_beat  = cnt == LastBeat;
    assign din_fire   = (state == WDATA) && WDataValid && DataInReady;
    assign drain_fire = (state == DRAIN) && WDataValid;
    assign dout_fire  = (state == RDATA) && DataOutValid;

    // armed keeps ReqReady low for the first cycle out of reset
    assign ReqReady     = armed && (state == IDLE);
    assign CmdValid     = state == CMD;
    assign DataIn       = (state == WDATA) ? WData : '0;
    assign DataInValid  = (state == WDATA) && WDataValid;
    assign WDataReady   = ((state == WDATA) && DataInReady) || (state == DRAIN);
    assign DataOutReady = state == RDATA;
    assign RespValid    = state == RESP;
    assign RespError    = (state == RESP) && err;
    assign RespLast     = (state == RESP) && (err || is_write || last_beat);
    assign RespData     = ((state == RESP) && !is_write && !err && buf_valid)
                        ? buffer[cnt] : '0;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_write  <= 1'b0;
            err       <= 1'b0;
            armed     <= 1'b0;
            buf_valid <= 1'b0;
            Cmd       <= '0;
            PAddr     <= '0;
            RespTag   <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_write  <= ReqWrite;
                        PAddr     <= ReqAddr;
                        RespTag   <= ReqTag;
                        Cmd       <= ReqWrite ? CMD_UPDATE : CMD_READ;
                        err       <= !in_range;
                        buf_valid <= 1'b0;
                        cnt       <= '0;
                        if (in_range)
                            state <= CMD;
                        else if (ReqWrite)
                            state <= DRAIN;
                        else
                            state <= RESP;
                    end
                end
                CMD: begin
                    if (CmdReady) begin
                        cnt   <= '0;
                        state <= is_write ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (din_fire) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_fire) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (dout_fire) begin
                        if (last_beat) begin
                            cnt       <= '0;
                            buf_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        if (RespLast) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // the read buffer carries no reset; buf_valid guards its use
    always_ff @(posedge Clock) begin
        if (Reset && dout_fire)
            buffer[cnt] <= DataOut;
    end

endmodule

// File: tb/tb_oram_host_adapter.sv
// Randomized bench for oram_host_adapter with a transaction-level model
// of the host, the core and the expected responses.
module tb_oram_host_adapter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [31:0] ReqAddr = '0;
    logic [3:0]  ReqTag = '0;
    logic [63:0] WData = '0;
    logic        WDataValid = 1'b0;
    logic        WDataReady;
    logic [63:0] RespData;
    logic [3:0]  RespTag;
    logic        RespError;
    logic        RespLast;
    logic        RespValid;
    logic        RespReady = 1'b0;
    logic [1:0]  Cmd;
    logic [31:0] PAddr;
    logic        CmdValid;
    logic        CmdReady = 1'b0;
    logic [63:0] DataIn;
    logic        DataInValid;
    logic        DataInReady = 1'b0;
    logic [63:0] DataOut = '0;
    logic        DataOutValid = 1'b0;
    logic        DataOutReady;

    always #5 Clock = ~Clock;

    oram_host_adapter dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqTag(ReqTag),
        .WData(WData), .WDataValid(WDataValid), .WDataReady(WDataReady),
        .RespData(RespData), .RespTag(RespTag), .RespError(RespError),
        .RespLast(RespLast), .RespValid(RespValid), .RespReady(RespReady),
        .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        last;
    } resp_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model state
    bit          busy, post_reset, cmd_pending, cmd_done, resp_active;
    bit          cur_write, cur_err;
    logic [3:0]  cur_tag;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_addr;
    int          din_rem, drain_rem;
    logic [63:0] exp_din[$];
    logic [63:0] hostw[$];
    logic [63:0] coreq[$];
    resp_t       exp_resp[$];

    // host request being offered
    bit          req_pending;
    logic        r_write;
    logic [31:0] r_addr;
    logic [3:0]  r_tag;
    logic [63:0] r_data[8];

    int  mode = 0;
    bit  gen_en = 1'b1;
    int  rst_cycles = 3;
    int  resets_left = 3;
    int  resp_stall = 0;
    int  done_reqs = 0;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic new_req();
        int k;
        k = $urandom_range(0, 9);
        r_write = $urandom_range(0, 1) == 1;
        case (k)
            0: r_addr = 32'd1023;
            1: r_addr = 32'd1024;
            2: r_addr = 32'hFFFF_FFFF;
            3: r_addr = 32'd0;
            4: r_addr = $urandom;
            default: r_addr = $urandom_range(0, 1023);
        endcase
        r_tag = 4'($urandom);
        for (int i = 0; i < 8; i++) r_data[i] = rand64();
        req_pending = 1'b1;
    endtask

    task automatic model_reset();
        busy = 0; cmd_pending = 0; cmd_done = 0; resp_active = 0;
        din_rem = 0; drain_rem = 0;
        exp_din.delete(); hostw.delete(); coreq.delete(); exp_resp.delete();
        post_reset = 1;
    endtask

    task automatic cycle();
        bit wphase, dphase, go_resp;
        resp_t r;
        @(negedge Clock);
        Reset = (rst_cycles == 0);
        if (!req_pending && gen_en && $urandom_range(0, 2) == 0) new_req();
        ReqValid = req_pending;
        ReqWrite = r_write;
        ReqAddr  = r_addr;
        ReqTag   = r_tag;
        WDataValid = hostw.size() > 0 && (mode == 0 || $urandom_range(0, 3) != 0);
        WData = hostw.size() > 0 ? hostw[0] : rand64();
        if (resp_stall > 0) begin
            RespReady = 1'b0;
            resp_stall--;
        end else if (mode == 1 && RespValid && $urandom_range(0, 30) == 0) begin
            RespReady = 1'b0;
            resp_stall = 19;
        end else begin
            RespReady = mode == 0 || $urandom_range(0, 3) != 0;
        end
        CmdReady    = mode == 0 || $urandom_range(0, 2) == 0;
        DataInReady = mode == 0 || $urandom_range(0, 3) != 0;
        DataOutValid = coreq.size() > 0 && (mode == 0 || $urandom_range(0, 3) != 0);
        DataOut = coreq.size() > 0 ? coreq[0] : rand64();
        #1;
        if (!Reset) begin
            model_reset();
            if (rst_cycles > 0) rst_cycles--;
            return;
        end
        wphase = busy && cur_write && !cur_err && cmd_done && din_rem > 0;
        dphase = busy && cur_write && cur_err && drain_rem > 0;
        go_resp = 0;

        check("req_ready", ReqReady, !busy && !post_reset);
        check("cmd_valid", CmdValid, cmd_pending);
        if (CmdValid) begin
            check("cmd", Cmd, exp_cmd);
            check("paddr", PAddr, exp_addr);
        end
        check("din_valid", DataInValid, wphase && WDataValid);
        check("wdata_ready", WDataReady, (wphase && DataInReady) || dphase);
        if (DataInValid && exp_din.size() > 0)
            check("din_data", DataIn, exp_din[0]);
        check("dout_ready", DataOutReady, coreq.size() > 0);
        check("resp_valid", RespValid, resp_active);
        if (RespValid && exp_resp.size() > 0) begin
            check("resp_data", RespData, exp_resp[0].data);
            check("resp_err", RespError, exp_resp[0].err);
            check("resp_last", RespLast, exp_resp[0].last);
            check("resp_tag", RespTag, cur_tag);
        end
        if (post_reset) begin
            check("rst_cmd", Cmd, 0);
            check("rst_paddr", PAddr, 0);
            check("rst_tag", RespTag, 0);
            check("rst_rdata", RespData, 0);
            check("rst_last", RespLast, 0);
            check("rst_err", RespError, 0);
        end

        if (ReqValid && ReqReady) begin
            req_pending = 0;
            busy = 1;
            cur_write = r_write;
            cur_tag = r_tag;
            cur_err = r_addr >= 32'd1024;
            cmd_done = 0;
            if (r_write)
                for (int i = 0; i < 8; i++) hostw.push_back(r_data[i]);
            if (!cur_err) begin
                cmd_pending = 1;
                exp_cmd = r_write ? 2'd0 : 2'd2;
                exp_addr = r_addr;
                if (r_write) begin
                    for (int i = 0; i < 8; i++) exp_din.push_back(r_data[i]);
                    din_rem = 8;
                    r.data = 0; r.err = 0; r.last = 1;
                    exp_resp.push_back(r);
                end
            end else begin
                r.data = 0; r.err = 1; r.last = 1;
                exp_resp.push_back(r);
                if (r_write) drain_rem = 8;
                else go_resp = 1;
            end
        end
        if (CmdValid && CmdReady) begin
            cmd_pending = 0;
            cmd_done = 1;
            if (!cur_write) begin
                for (int i = 0; i < 8; i++) begin
                    r.data = rand64(); r.err = 0; r.last = (i == 7);
                    coreq.push_back(r.data);
                    exp_resp.push_back(r);
                end
            end
        end
        if (WDataValid && WDataReady) begin
            if (hostw.size() > 0) void'(hostw.pop_front());
            if (wphase) begin
                if (exp_din.size() > 0) void'(exp_din.pop_front());
                din_rem--;
                if (din_rem == 0) go_resp = 1;
            end else if (dphase) begin
                drain_rem--;
                if (drain_rem == 0) go_resp = 1;
            end
        end
        if (DataOutValid && DataOutReady && coreq.size() > 0) begin
            void'(coreq.pop_front());
            if (coreq.size() == 5 && mode == 1 && resets_left > 0) begin
                resets_left--;
                rst_cycles = 1;
            end
            if (coreq.size() == 0) go_resp = 1;
        end
        if (RespValid && RespReady && exp_resp.size() > 0) begin
            r = exp_resp.pop_front();
            if (r.last) begin
                busy = 0;
                resp_active = 0;
                done_reqs++;
            end
        end
        if (go_resp) resp_active = 1;
        post_reset = 0;
    endtask

    initial begin
        model_reset();
        for (int c = 0; c < 400; c++) cycle();
        mode = 1;
        for (int c = 0; c < 8000; c++) cycle();
        gen_en = 0;
        for (int c = 0; c < 3000 && (busy || req_pending); c++) cycle();
        check("drain_done", busy || req_pending, 0);
        check("progress", done_reqs > 50, 1);
        check("resets_done", resets_left, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
